// File: rtl/calc_key_ctrl.sv
// Keypad calculator controller: collects two BCD operands and an operator,
// then runs a digit-serial BCD add/subtract and, for negative results, a negate pass.
module calc_key_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            key_i,
  input  logic                  key_valid_i,
  output logic [4*DIGITS-1:0]   disp_bcd_o,
  output logic                  disp_neg_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    CALC,
    NEG,
    SHOW
  } state_t;

  state_t          state_q, state_nxt;
  logic [W-1:0]    a_q, a_nxt, b_q, b_nxt, r_q, r_nxt;
  logic            op_q, op_nxt;
  logic [CW-1:0]   cnt_a_q, cnt_a_nxt, cnt_b_q, cnt_b_nxt;
  logic [IW-1:0]   idx_q, idx_nxt;
  logic            c_q, c_nxt;
  logic            neg_q, neg_nxt;
  logic            err_q, err_nxt;
  logic            done_q, done_nxt;

  logic            is_digit, is_op, is_eq, key_minus;
  logic            sub;
  logic [3:0]      x_dig, y_dig, res_dig;
  logic [4:0]      sum5, dif5;
  logic            c_out;

  assign is_digit  = key_valid_i && (key_i <= 4'd9);
  assign is_op     = key_valid_i && ((key_i == 4'd10) || (key_i == 4'd11));
  assign is_eq     = key_valid_i && (key_i == 4'd12);
  assign key_minus = (key_i == 4'd10);

  // Shared digit unit: CALC works on A op B, NEG reuses the subtractor as 0 - R.
  always_comb begin
    sub   = (state_q == NEG) || op_q;
    x_dig = (state_q == NEG) ? 4'd0 : a_q[idx_q*4 +: 4];
    y_dig = (state_q == NEG) ? r_q[idx_q*4 +: 4] : b_q[idx_q*4 +: 4];
    sum5  = {1'b0, x_dig} + {1'b0, y_dig} + {4'b0, c_q};
    dif5  = {1'b0, x_dig} - {1'b0, y_dig} - {4'b0, c_q};
    if (sub) begin
      c_out   = dif5[4];
      res_dig = c_out ? (dif5[3:0] + 4'd10) : dif5[3:0];
    end else begin
      c_out   = (sum5 > 5'd9);
      res_dig = c_out ? (sum5[3:0] - 4'd10) : sum5[3:0];
    end
  end

  always_comb begin
    state_nxt = state_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    r_nxt     = r_q;
    op_nxt    = op_q;
    cnt_a_nxt = cnt_a_q;
    cnt_b_nxt = cnt_b_q;
    idx_nxt   = idx_q;
    c_nxt     = c_q;
    neg_nxt   = neg_q;
    err_nxt   = err_q;
    done_nxt  = 1'b0;

    unique case (state_q)
      ENTER_A: begin
        if (is_digit) begin
          if (cnt_a_q < CNT_MAX) begin
            a_nxt     = {a_q[W-5:0], key_i};
            cnt_a_nxt = cnt_a_q + CW'(1);
          end
        end else if (is_op) begin
          op_nxt    = key_minus;
          b_nxt     = '0;
          cnt_b_nxt = '0;
          state_nxt = ENTER_B;
        end
      end

      ENTER_B: begin
        if (is_digit) begin
          if (cnt_b_q < CNT_MAX) begin
            b_nxt     = {b_q[W-5:0], key_i};
            cnt_b_nxt = cnt_b_q + CW'(1);
          end
        end else if (is_op) begin
          op_nxt = key_minus;
        end else if (is_eq) begin
          idx_nxt   = '0;
          c_nxt     = 1'b0;
          state_nxt = CALC;
        end
      end

      CALC: begin
        r_nxt[idx_q*4 +: 4] = res_dig;
        c_nxt   = c_out;
        idx_nxt = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
          if (!op_q) begin
            err_nxt   = c_out;
            if (c_out) r_nxt = '0;
            neg_nxt   = 1'b0;
            state_nxt = SHOW;
            done_nxt  = 1'b1;
          end else if (c_out) begin
            idx_nxt   = '0;
            c_nxt     = 1'b0;
            state_nxt = NEG;
          end else begin
            neg_nxt   = 1'b0;
            state_nxt = SHOW;
            done_nxt  = 1'b1;
          end
        end
      end

      NEG: begin
        r_nxt[idx_q*4 +: 4] = res_dig;
        c_nxt   = c_out;
        idx_nxt = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
          neg_nxt   = 1'b1;
          state_nxt = SHOW;
          done_nxt  = 1'b1;
        end
      end

      SHOW: begin
        if (is_digit) begin
          a_nxt     = W'(key_i);
          cnt_a_nxt = CW'(1);
          neg_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = ENTER_A;
        end else if (is_op && !err_q && !neg_q) begin
          a_nxt     = r_q;
          cnt_a_nxt = CNT_MAX;
          op_nxt    = key_minus;
          b_nxt     = '0;
          cnt_b_nxt = '0;
          state_nxt = ENTER_B;
        end
      end

      default: state_nxt = ENTER_A;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      r_q     <= r_nxt;
      op_q    <= op_nxt;
      cnt_a_q <= cnt_a_nxt;
      cnt_b_q <= cnt_b_nxt;
      idx_q   <= idx_nxt;
      c_q     <= c_nxt;
      neg_q   <= neg_nxt;
      err_q   <= err_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    unique case (state_q)
      ENTER_A:        disp_bcd_o = a_q;
      SHOW:           disp_bcd_o = r_q;
      default:        disp_bcd_o = b_q;
    endcase
  end

  assign disp_neg_o = neg_q && (state_q == SHOW);
  assign err_o      = err_q;
  assign busy_o     = (state_q == CALC) || (state_q == NEG);
  assign done_o     = done_q;

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Bench for calc_key_ctrl: expected results are queued when '=' is keyed and
// checked by a monitor when done_o pulses.
module tb_calc_key_ctrl;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key = '0;
  logic        key_valid = 1'b0;
  logic [15:0] disp_bcd;
  logic        disp_neg, err, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    logic        err;
  } exp_t;

  exp_t sb[$];

  calc_key_ctrl #(.DIGITS(DIGITS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_i       (key),
    .key_valid_i (key_valid),
    .disp_bcd_o  (disp_bcd),
    .disp_neg_o  (disp_neg),
    .err_o       (err),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] res;
    int t;
    t = v;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      res[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return res;
  endfunction

  function automatic exp_t model(input int a, input int b, input bit minus);
    exp_t e;
    e.neg = 1'b0;
    e.err = 1'b0;
    if (!minus) begin
      if (a + b > 9999) begin
        e.err = 1'b1;
        e.bcd = '0;
      end else begin
        e.bcd = to_bcd(a + b);
      end
    end else if (a >= b) begin
      e.bcd = to_bcd(a - b);
    end else begin
      e.bcd = to_bcd(b - a);
      e.neg = 1'b1;
    end
    return e;
  endfunction

  // Result monitor: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done got=done exp=no_result_pending");
      end else begin
        e = sb.pop_front();
        if ({disp_bcd, disp_neg, err} !== {e.bcd, e.neg, e.err}) begin
          bad++;
          $display("FAIL sb_result got=%h neg=%b err=%b exp=%h neg=%b err=%b",
                   disp_bcd, disp_neg, err, e.bcd, e.neg, e.err);
        end
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key = '0;
  endtask

  task automatic press_num(input int v);
    int d[$];
    int t;
    t = v;
    do begin
      d.push_front(t % 10);
      t = t / 10;
    end while (t > 0);
    foreach (d[n]) press(4'(d[n]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_done(output int bc, output bit seen);
    bc = 0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({disp_bcd, disp_neg, err, busy, done} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%b%b%b%b exp=0000/0000",
               disp_bcd, disp_neg, err, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int bc;
    bit seen;
    press_num(12);
    total++;
    if (disp_bcd !== 16'h0012) begin
      bad++; $display("FAIL add_enter_a got=%h exp=0012", disp_bcd);
    end
    press(4'd11);
    press_num(34);
    total++;
    if (disp_bcd !== 16'h0034) begin
      bad++; $display("FAIL add_enter_b got=%h exp=0034", disp_bcd);
    end
    sb.push_back(model(12, 34, 1'b0));
    press(4'd12);
    wait_done(bc, seen);
    total++;
    if (!seen || bc != 4) begin
      bad++; $display("FAIL add_busy got=%0d seen=%b exp=4 seen=1", bc, seen);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL add_done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_sub_neg();
    int bc;
    bit seen;
    do_reset();
    press_num(15);
    press(4'd10);
    press_num(27);
    sb.push_back(model(15, 27, 1'b1));
    press(4'd12);
    wait_done(bc, seen);
    total++;
    if (!seen || bc != 8) begin
      bad++; $display("FAIL sub_busy got=%0d seen=%b exp=8 seen=1", bc, seen);
    end
    press(4'd3);
    total++;
    if ({disp_bcd, disp_neg} !== {16'h0003, 1'b0}) begin
      bad++; $display("FAIL sub_new_digit got=%h neg=%b exp=0003 neg=0", disp_bcd, disp_neg);
    end
  endtask

  task automatic test_overflow();
    int bc;
    bit seen;
    do_reset();
    press_num(9999);
    press(4'd11);
    press_num(1);
    sb.push_back(model(9999, 1, 1'b0));
    press(4'd12);
    wait_done(bc, seen);
    total++;
    if (!seen || bc != 4) begin
      bad++; $display("FAIL ovf_busy got=%0d seen=%b exp=4 seen=1", bc, seen);
    end
    press(4'd11);
    press(4'd12);
    @(negedge clk);
    total++;
    if ({disp_bcd, err, busy} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ovf_op_ignored got=%h err=%b busy=%b exp=0000 err=1 busy=0",
                      disp_bcd, err, busy);
    end
  endtask

  task automatic test_entry_limit();
    logic [3:0] inv;
    do_reset();
    press_num(12345);
    total++;
    if (disp_bcd !== 16'h1234) begin
      bad++; $display("FAIL limit_fifth_digit got=%h exp=1234", disp_bcd);
    end
    for (int k = 13; k <= 15; k++) begin
      inv = 4'(k);
      press(inv);
      total++;
      if ({disp_bcd, busy} !== {16'h1234, 1'b0}) begin
        bad++; $display("FAIL limit_invalid_%0d got=%h exp=1234", k, disp_bcd);
      end
    end
    press(4'd10);
    press(4'd15);
    press(4'd6);
    total++;
    if (disp_bcd !== 16'h0006) begin
      bad++; $display("FAIL limit_b_after_invalid got=%h exp=0006", disp_bcd);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    bit seen;
    do_reset();
    press_num(2);
    press(4'd11);
    press_num(3);
    sb.push_back(model(2, 3, 1'b0));
    press(4'd12);
    wait_done(bc, seen);
    total++;
    if (!seen || bc != 4) begin
      bad++; $display("FAIL chain1_busy got=%0d seen=%b exp=4 seen=1", bc, seen);
    end
    press(4'd11);
    total++;
    if (disp_bcd !== 16'h0000) begin
      bad++; $display("FAIL chain_b_cleared got=%h exp=0000", disp_bcd);
    end
    press_num(4);
    sb.push_back(model(5, 4, 1'b0));
    press(4'd12);
    press(4'd7);
    wait_done(bc, seen);
    total++;
    if (!seen) begin
      bad++; $display("FAIL chain2_timeout got=none exp=done");
    end
    repeat (2) @(negedge clk);
    total++;
    if ({disp_bcd, busy, sb.size() == 0} !== {16'h0009, 1'b0, 1'b1}) begin
      bad++; $display("FAIL chain_busy_key_dropped got=%h busy=%b pending=%0d exp=0009 busy=0 pending=0",
                      disp_bcd, busy, sb.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    press_num(5);
    press(4'd11);
    press_num(6);
    press(4'd12);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL arst_in_calc got=%b exp=1", busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({disp_bcd, disp_neg, err, busy, done} !== 20'h0) begin
      bad++; $display("FAIL arst_outputs got=%h/%b%b%b%b exp=0000/0000",
                      disp_bcd, disp_neg, err, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    press(4'd7);
    total++;
    if (disp_bcd !== 16'h0007) begin
      bad++; $display("FAIL arst_next_digit got=%h exp=0007", disp_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_neg();
    test_overflow();
    test_entry_limit();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_key_ctrl.md
# calc_key_ctrl

Keypad calculator controller sitting between the PS/2 key receiver and the 7-segment display driver. Consumes one decoded key code per `key_valid_i` pulse, assembles two unsigned BCD operands and an operator, and sequences a digit-serial BCD add/subtract datapath. Drives the BCD value to display plus sign, error and busy/done status.

## Interface
- `DIGITS`, default 4: operand/result width in decimal digits (≥2).
- `clk_i`: input, 1 bit, system clock; all state changes on its rising edge.
- `rst_i`: input, 1 bit, reset, asynchronous, active-high.
- `key_i`: input, 4 bits, key code:
  - 0–9 digit.
  - 10 minus.
  - 11 plus.
  - 12 equals.
  - 13–15 invalid.
- `key_valid_i`: input, 1 bit, one-cycle strobe qualifying `key_i`.
- `disp_bcd_o`: output, 4*DIGITS bits, BCD value to display, most significant digit in the top nibble.
- `disp_neg_o`: output, 1 bit, displayed value is negative.
- `err_o`: output, 1 bit, overflow on last calculation.
- `busy_o`: output, 1 bit, high in CALC/NEG; keys are dropped while high.
- `done_o`: output, 1 bit, one-cycle pulse when a result becomes valid.

## Operation
- Registers:
  - A, B, R: DIGITS-digit BCD each.
  - op: 1 bit, 0 = plus, 1 = minus.
  - cnt_a, cnt_b: digits entered.
  - digit index i.
  - carry/borrow bit.
  - neg, err.
- FSM states: ENTER_A, ENTER_B, CALC, NEG, SHOW. Reset state is ENTER_A.
- ENTER_A:
  - Digit key: if cnt_a < DIGITS, A ← A<<4 | key, cnt_a++; otherwise ignored.
  - Op key: op latched, B and cnt_b cleared, go to ENTER_B.
  - Equals or invalid key: ignored.
- ENTER_B:
  - Digit key: shifts into B, same limit rule as ENTER_A.
  - Op key: replaces op, B unchanged.
  - Equals: i←0, carry←0, go to CALC.
- CALC, one digit per cycle, LSD first:
  - Plus: s = A[i]+B[i]+c. If s>9, digit = s−10 and c=1; else digit = s and c=0.
  - Minus: d = A[i]−B[i]−c. If d<0, digit = d+10 and c=1; else digit = d and c=0.
  - Result digit is written to R[i].
  - After digit DIGITS−1, plus: err←c. If err, R←0. neg←0. Go to SHOW.
  - After digit DIGITS−1, minus with final borrow: i←0, c←0, go to NEG.
  - After digit DIGITS−1, minus without final borrow: neg←0, go to SHOW.
- NEG: computes R ← 0 − R digit-serially with the same subtract rule, over DIGITS cycles. Then neg←1, go to SHOW.
- SHOW:
  - Digit key: A←key, cnt_a←1, neg←0, err←0, go to ENTER_A.
  - Op key with err=0 and neg=0: A←R, cnt_a←DIGITS, op latched, B cleared, go to ENTER_B (chaining).
  - Op key with err or neg set: ignored.
  - Equals or invalid key: ignored.
- Display select:
  - ENTER_A shows A.
  - ENTER_B, CALC and NEG show B.
  - SHOW shows R.
  - `disp_neg_o` = neg && state==SHOW.
  - `err_o` = err.
- Any key strobe in CALC/NEG is discarded; there is no queuing.

## Timing
- Reset values:
  - All registers 0, state ENTER_A.
  - `disp_bcd_o`=0, `disp_neg_o`=0, `err_o`=0, `busy_o`=0, `done_o`=0.
- Reset mid-operation (any state) aborts immediately to these values.
- A key is sampled on the rising edge where `key_valid_i`=1. The effect is visible on `disp_bcd_o` in the following cycle.
- Equals sampled at edge E:
  - CALC digit i is written at edge E+1+i.
  - SHOW is entered at edge E+DIGITS; `done_o`=1 for exactly the cycle after that edge.
  - Negative result: NEG occupies edges E+DIGITS+1 … E+2·DIGITS. SHOW and `done_o` follow edge E+2·DIGITS.
- `busy_o` is registered from the state: high exactly for the cycles spent in CALC/NEG.
- `key_valid_i` held high for several cycles counts as one key per cycle; the upstream strobe is single-cycle by contract.
- Invalid codes 13–15 never change state in any state.

## Test plan
- DIGITS=4, keys 1,2,+,3,4,= → `busy_o` high 4 cycles, `done_o` pulse, `disp_bcd_o`=0x0046, `disp_neg_o`=0, `err_o`=0.
- Keys 1,5,−,2,7,= → 8 busy cycles, `disp_bcd_o`=0x0012, `disp_neg_o`=1; then digit 3 → display 0x0003, neg 0.
- Keys 9,9,9,9,+,1,= → `err_o`=1, `disp_bcd_o`=0x0000; a following op key is ignored (state stays SHOW).
- Keys 1,2,3,4,5 → `disp_bcd_o`=0x1234, fifth digit dropped; keys 13/14/15 produce no change.
- Keys 2,+,3,=, then +,4,= → 0x0005, then chained 0x0009. A key strobed during `busy_o` is ignored; result unchanged.
- Assert `rst_i` asynchronously during CALC → all outputs 0 immediately. Next digit key 7 → display 0x0007.
